// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer with start, LSB-first data, optional parity
// (even/odd/mark/space) and 1 or 2 stop bits, timed by an internal bit divider.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  FRAME_DONE
);
    localparam int DIVW = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

    state_t                state, state_n;
    logic [DIVW-1:0]       div, div_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_q, par_en_q, stop2_q;
    logic                  accept, tick, tx_n, done_n, par_calc;

    // Mark/space force the bit; even/odd differ only by an inversion of the XOR.
    assign par_calc = PAR_MODE[1] ? ~PAR_MODE[0] : (^P_DATA) ^ PAR_MODE[0];

    always_comb begin
        accept  = (state == S_IDLE) && Data_Valid && !Busy;
        tick    = (div == DIVW'(CLKS_PER_BIT - 1));
        state_n = state;
        div_n   = tick ? '0 : div + 1'b1;
        idx_n   = idx;
        done_n  = 1'b0;
        if (state == S_IDLE) begin
            div_n = '0;
            if (accept) state_n = S_START;
        end else if (tick) begin
            case (state)
                S_START:  state_n = S_DATA;
                S_DATA: begin
                    if (idx == IW'(DATA_WIDTH - 1)) begin
                        idx_n   = '0;
                        state_n = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                S_PARITY: state_n = S_STOP1;
                S_STOP1: begin
                    state_n = stop2_q ? S_STOP2 : S_IDLE;
                    done_n  = !stop2_q;
                end
                S_STOP2: begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
        tx_n = (state_n == S_START)  ? 1'b0 :
               (state_n == S_DATA)   ? shreg[idx_n] :
               (state_n == S_PARITY) ? par_q : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            div        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            TX_OUT     <= 1'b1;
            Busy       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            idx        <= idx_n;
            TX_OUT     <= tx_n;
            Busy       <= (state_n != S_IDLE);
            FRAME_DONE <= done_n;
            if (accept) begin
                shreg    <= P_DATA;
                par_q    <= par_calc;
                par_en_q <= PAR_EN;
                stop2_q  <= STOP2;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench; expected frames are built from the framing
// rules and compared against the line by an independent monitor.
module tb_uart_tx_frame;
    localparam int CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic [1:0] PAR_MODE = '0;
    logic       STOP2 = 1'b0;
    logic       TX_OUT, Busy, FRAME_DONE;

    int     passed = 0, total = 0, cyc = 0, fd_count = 0;
    logic   mon_en = 1'b0;
    frame_t sb[$];
    int     done_q[$];

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .STOP2(STOP2),
        .TX_OUT(TX_OUT), .Busy(Busy), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (FRAME_DONE) fd_count <= fd_count + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    function automatic frame_t model(input logic [7:0] d, input logic pe, input logic [1:0] pm, input logic s2);
        frame_t f;
        int     n = 0;
        int     ones = $countones(d);
        logic   p;
        f.bits = '0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pe) begin
            case (pm)
                2'b00:   p = (ones % 2 == 1);
                2'b01:   p = (ones % 2 == 0);
                2'b10:   p = 1'b1;
                default: p = 1'b0;
            endcase
            f.bits[n] = p;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (Busy && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (Busy) check("idle_timeout", Busy, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic [1:0] pm, input logic s2);
        wait_idle();
        P_DATA = d; PAR_EN = pe; PAR_MODE = pm; STOP2 = s2; Data_Valid = 1'b1;
        sb.push_back(model(d, pe, pm, s2));
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    initial begin
        frame_t      exp;
        logic [15:0] got;
        logic        busy_ok;
        int          n;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            if (Busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", Busy, 0);
                    n = 0;
                    while (Busy && n < 2000) begin
                        @(negedge CLK);
                        n++;
                    end
                end else begin
                    exp = sb.pop_front();
                    got = exp.bits;
                    busy_ok = 1'b1;
                    for (int c = 0; c < exp.len * CPB; c++) begin
                        if (c > 0) @(negedge CLK);
                        if (TX_OUT !== exp.bits[c / CPB]) got[c / CPB] = TX_OUT;
                        if (Busy !== 1'b1 || FRAME_DONE !== 1'b0) busy_ok = 1'b0;
                    end
                    check("frame_bits", got, exp.bits);
                    check("busy_window", busy_ok, 1);
                    @(negedge CLK);
                    check("done_pulse", FRAME_DONE, 1);
                    check("busy_fall", Busy, 0);
                    check("idle_line", TX_OUT, 1);
                    done_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_before, n, seen;
        repeat (3) @(negedge CLK);
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", Busy, 0);
        check("rst_done", FRAME_DONE, 0);
        RST = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_MODE = 2'b00; STOP2 = 1'b0; Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        repeat (17) @(posedge CLK);
        #2;
        check("pre_abort_bit3", TX_OUT, 0);
        check("pre_abort_busy", Busy, 1);
        fd_before = fd_count;
        RST = 1'b0;
        #1;
        check("abort_tx", TX_OUT, 1);
        check("abort_busy", Busy, 0);
        check("abort_done", FRAME_DONE, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rel_tx", TX_OUT, 1);
        check("post_rel_busy", Busy, 0);
        check("abort_no_done", fd_count, fd_before);
        mon_en = 1'b1;

        send(8'hA5, 1'b1, 2'b00, 1'b0);
        send(8'h07, 1'b1, 2'b01, 1'b0);
        send(8'h07, 1'b1, 2'b10, 1'b0);
        send(8'h07, 1'b1, 2'b11, 1'b0);
        send(8'h00, 1'b1, 2'b00, 1'b0);
        send(8'hFF, 1'b0, 2'b01, 1'b1);

        send(8'h12, 1'b1, 2'b00, 1'b0);
        repeat (10) @(negedge CLK);
        P_DATA = 8'h3C; PAR_MODE = 2'b01; STOP2 = 1'b1; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle();
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (Busy) seen = 1;
        end
        check("no_second_frame", seen, 0);

        wait_idle();
        P_DATA = 8'h55; PAR_EN = 1'b1; PAR_MODE = 2'b00; STOP2 = 1'b0; Data_Valid = 1'b1;
        sb.push_back(model(8'h55, 1'b1, 2'b00, 1'b0));
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FRAME_DONE && n < 2000);
        check("b2b_done_seen", FRAME_DONE, 1);
        check("b2b_gap_high", TX_OUT, 1);
        P_DATA = 8'hAA;
        sb.push_back(model(8'hAA, 1'b1, 2'b00, 1'b0));
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        @(negedge CLK);
        check("b2b_start_low", TX_OUT, 0);
        wait_idle();
        @(negedge CLK);
        if (done_q.size() >= 2) check("b2b_spacing", done_q[done_q.size() - 1] - done_q[done_q.size() - 2], 11 * CPB + 1);
        else check("b2b_done_count", done_q.size(), 2);

        for (int i = 0; i < 20; i++)
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        wait_idle();
        repeat (5) @(negedge CLK);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
